pit_payload_buffer: RTL and testbench

- Downstream stage of the PIT hash table. Consumes each lookup result: `pit_in_bit`, `table_entry`, `meta_data`, `rejected` and `interest_packet`.
- Stores FIB-delivered data payloads into a slot-addressed byte buffer.
- Streams the stored payload back toward the SPI side when an interest hits cached data, or when data arrives for a pending interest.
- Discards payload bytes of rejected (unrequested) data packets so the input stream stays aligned.

---
 rtl/pit_pkg.sv | 25 ++
 rtl/pit_slot_ram.sv | 34 +++
 rtl/pit_payload_buffer.sv | 162 ++++++++++++++++
 tb/tb_pit_payload_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// Shared constants, state encoding and length decode for the PIT payload buffer.
package pit_pkg;

    localparam logic [1:0] MT_INTEREST = 2'b01;
    localparam logic [1:0] MT_DATA     = 2'b10;

    localparam int ENTRY_CACHED_BIT = 10;
    localparam int ENTRY_ADDR_MSB   = 9;

    localparam int IDX_W = 6;
    localparam int LEN_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    // The 6-bit length field cannot express 64, so 0 stands for a full slot.
    function automatic logic [LEN_W-1:0] decode_len(input logic [IDX_W-1:0] l);
        return (l == '0) ? LEN_W'(64) : {1'b0, l};
    endfunction

endpackage

// File: rtl/pit_slot_ram.sv
// Slot-addressed payload byte array plus per-slot stored length.
module pit_slot_ram
    import pit_pkg::*;
#(
    parameter int SLOT_W     = 4,
    parameter int SLOT_BYTES = 64
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_len_we,
    input  logic [SLOT_W-1:0] i_waddr,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [7:0]        i_wdata,
    input  logic [LEN_W-1:0]  i_wlen,
    input  logic [SLOT_W-1:0] i_raddr,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [7:0]        o_rdata,
    output logic [LEN_W-1:0]  o_rlen
);

    logic [7:0]       r_mem [2**SLOT_W][SLOT_BYTES];
    logic [LEN_W-1:0] r_len [2**SLOT_W];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr][i_widx] <= i_wdata;
        if (i_len_we)
            r_len[i_waddr] <= i_wlen;
    end

    assign o_rdata = r_mem[i_raddr][i_ridx];
    assign o_rlen  = r_len[i_raddr];

endmodule

// File: rtl/pit_payload_buffer.sv
// Stores FIB payloads per PIT slot and streams them toward SPI on a cache hit
// or when data answers a pending interest; discards bytes of rejected data.
module pit_payload_buffer
    import pit_pkg::*;
#(
    parameter int SLOT_W     = 4,
    parameter int SLOT_BYTES = 64,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pit_in_bit,
    input  logic [10:0]           table_entry,
    input  logic [7:0]            meta_data,
    input  logic                  rejected,
    input  logic                  interest_packet,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t                r_state, w_next;
    logic [SLOT_W-1:0]     r_slot;
    logic [LEN_W-1:0]      r_len, r_cnt;
    logic                  r_fwd;
    logic [7:0]            r_out_byte;
    logic                  r_out_valid, r_out_last;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic             w_go_drop, w_go_write, w_go_read;
    logic             w_in_fire, w_in_last, w_load, w_done, w_lost;
    logic             w_mem_we, w_len_we;
    logic [7:0]       w_rdata;
    logic [LEN_W-1:0] w_rlen;
    logic             w_unused;

    // Upper PIT address bits do not select a slot; slots wrap.
    assign w_unused = ^table_entry[ENTRY_ADDR_MSB:SLOT_W];

    assign in_ready  = (r_state == ST_WRITE) || (r_state == ST_DROP);
    assign busy      = (r_state != ST_IDLE);
    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign drop_cnt  = r_drop_cnt;

    assign w_in_fire = in_valid && in_ready;
    assign w_in_last = (r_cnt == r_len - LEN_W'(1));
    assign w_lost    = busy && (pit_in_bit || rejected);

    always_comb begin
        w_next     = r_state;
        w_go_drop  = 1'b0;
        w_go_write = 1'b0;
        w_go_read  = 1'b0;
        w_mem_we   = 1'b0;
        w_len_we   = 1'b0;
        w_load     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rejected) begin
                    w_go_drop = 1'b1;
                    w_next    = ST_DROP;
                end else if (pit_in_bit && meta_data[7:6] == MT_DATA) begin
                    w_go_write = 1'b1;
                    w_next     = ST_WRITE;
                end else if (pit_in_bit && meta_data[7:6] == MT_INTEREST
                             && table_entry[ENTRY_CACHED_BIT]) begin
                    w_go_read = 1'b1;
                    w_next    = ST_READ;
                end
            end
            ST_WRITE: begin
                w_mem_we = w_in_fire;
                if (w_in_fire && w_in_last) begin
                    w_len_we = 1'b1;
                    w_next   = r_fwd ? ST_READ : ST_IDLE;
                end
            end
            ST_READ: begin
                w_done = r_out_valid && out_ready && r_out_last;
                // Refill the output register whenever it is empty or being taken.
                w_load = (r_cnt < w_rlen) && (!r_out_valid || out_ready);
                if (w_done)
                    w_next = ST_IDLE;
            end
            ST_DROP: begin
                if (w_in_fire && w_in_last)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_fwd       <= 1'b0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_go_drop) begin
                r_len <= decode_len(meta_data[IDX_W-1:0]);
                r_cnt <= '0;
            end
            if (w_go_write) begin
                r_slot <= table_entry[SLOT_W-1:0];
                r_len  <= decode_len(meta_data[IDX_W-1:0]);
                r_fwd  <= interest_packet;
                r_cnt  <= '0;
            end
            if (w_go_read) begin
                r_slot <= table_entry[SLOT_W-1:0];
                r_cnt  <= '0;
            end
            if (w_in_fire)
                r_cnt <= w_in_last ? '0 : r_cnt + LEN_W'(1);
            if (w_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_load) begin
                r_out_byte  <= w_rdata;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_cnt == w_rlen - LEN_W'(1));
                r_cnt       <= r_cnt + LEN_W'(1);
            end
            if (w_lost && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    pit_slot_ram #(
        .SLOT_W     (SLOT_W),
        .SLOT_BYTES (SLOT_BYTES)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_mem_we),
        .i_len_we (w_len_we),
        .i_waddr  (r_slot),
        .i_widx   (r_cnt[IDX_W-1:0]),
        .i_wdata  (in_byte),
        .i_wlen   (r_len),
        .i_raddr  (r_slot),
        .i_ridx   (r_cnt[IDX_W-1:0]),
        .o_rdata  (w_rdata),
        .o_rlen   (w_rlen)
    );

endmodule

// File: tb/tb_pit_payload_buffer.sv
// Directed bench for pit_payload_buffer: stimulus pushes expected output bytes
// into a queue, an independent monitor pops and compares on each handshake.
module tb_pit_payload_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pit_in_bit = 1'b0;
    logic [10:0] table_entry = '0;
    logic [7:0]  meta_data = '0;
    logic        rejected = 1'b0;
    logic        interest_packet = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];   // {last, byte}
    logic       stalled = 1'b0;
    logic [7:0] held_byte = '0;

    always #5 clk = ~clk;

    pit_payload_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .pit_in_bit      (pit_in_bit),
        .table_entry     (table_entry),
        .meta_data       (meta_data),
        .rejected        (rejected),
        .interest_packet (interest_packet),
        .in_byte         (in_byte),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_byte        (out_byte),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted output byte against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_byte", 32'(out_byte), 32'(held_byte));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_byte), 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_byte", 32'(out_byte), 32'(e[7:0]));
                    chk("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            stalled   = out_valid && !out_ready;
            held_byte = out_byte;
        end
    end

    task automatic ev(input logic pit, input logic rej, input logic [10:0] te,
                      input logic [7:0] md, input logic ip);
        pit_in_bit = pit; rejected = rej; table_entry = te;
        meta_data = md; interest_packet = ip;
        @(posedge clk); #1;
        pit_in_bit = 1'b0; rejected = 1'b0; interest_packet = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1; in_byte = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        exp_q.push_back({last, b});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic read_slot5();
        push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
        ev(1'b1, 1'b0, 11'h405, 8'h40, 1'b0);
        drain();
    endtask

    function automatic logic [7:0] fwd_byte(input int i);
        return 8'(i * 3 + 7);
    endfunction

    initial begin
        logic [4:0] bp_seq;
        int n;
        bp_seq = 5'b11001;  // applied LSB first: 1,0,0,1,1

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then hit
        ev(1'b1, 1'b0, 11'h005, 8'h83, 1'b0);
        chk("write_busy", 32'(busy), 32'd1);
        feed(8'hAA); feed(8'hBB); feed(8'hCC);
        chk("write_done_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        read_slot5();

        // Backpressure: 1,0,0,1,1
        out_ready = 1'b0;
        push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
        ev(1'b1, 1'b0, 11'h405, 8'h40, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            out_ready = bp_seq[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Rejected drop with simultaneous pit_in_bit
        ev(1'b1, 1'b1, 11'h005, 8'h82, 1'b0);
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_no_valid", 32'(out_valid), 32'd0);
        feed(8'h11); feed(8'h22);
        chk("drop_done_busy", 32'(busy), 32'd0);
        chk("drop_no_valid2", 32'(out_valid), 32'd0);
        chk("drop_cnt_zero", 32'(drop_cnt), 32'd0);
        read_slot5();

        // Busy loss and slot wrap: 0x011 lands in slot 1
        ev(1'b1, 1'b0, 11'h011, 8'h82, 1'b0);
        pit_in_bit = 1'b1; table_entry = 11'h401; meta_data = 8'h41;
        @(posedge clk); @(posedge clk); #1;
        pit_in_bit = 1'b0;
        chk("drop_cnt_two", 32'(drop_cnt), 32'd2);
        feed(8'h5A); feed(8'hA5);
        push(8'h5A, 1'b0); push(8'hA5, 1'b1);
        ev(1'b1, 1'b0, 11'h401, 8'h40, 1'b0);
        drain();

        // Forward on interest_packet: length 0 -> 64 bytes, slot 2
        ev(1'b1, 1'b0, 11'h002, 8'h80, 1'b1);
        for (int i = 0; i < 64; i++) push(fwd_byte(i), i == 63);
        for (int i = 0; i < 64; i++) feed(fwd_byte(i));
        drain();
        chk("fwd_drop_cnt", 32'(drop_cnt), 32'd2);

        // Saturation: 300 lost events while a 64-byte write waits for data
        ev(1'b1, 1'b0, 11'h003, 8'h80, 1'b0);
        pit_in_bit = 1'b1; meta_data = 8'h41;
        for (int i = 0; i < 300; i++) @(posedge clk);
        #1;
        pit_in_bit = 1'b0;
        chk("sat_busy", 32'(busy), 32'd1);
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 64; i++) feed(8'(i));
        chk("sat_done_busy", 32'(busy), 32'd0);

        // Reset during the second byte of a read
        push(8'hAA, 1'b0);
        ev(1'b1, 1'b0, 11'h405, 8'h40, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        chk("mid_second_byte", 32'(out_byte), 32'hBB);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_q", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        read_slot5();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
